// File: rtl/chess_pkg.sv
// Shared chess definitions: figure codes, executor states and the start position.
package chess_pkg;

  localparam logic [3:0] EMPTY    = 4'd0;
  localparam logic [3:0] W_PAWN   = 4'd1;
  localparam logic [3:0] W_BISHOP = 4'd2;
  localparam logic [3:0] W_KNIGHT = 4'd3;
  localparam logic [3:0] W_ROOK   = 4'd4;
  localparam logic [3:0] W_QUEEN  = 4'd5;
  localparam logic [3:0] W_KING   = 4'd6;
  localparam logic [3:0] B_PAWN   = 4'd7;
  localparam logic [3:0] B_BISHOP = 4'd8;
  localparam logic [3:0] B_KNIGHT = 4'd9;
  localparam logic [3:0] B_ROOK   = 4'd10;
  localparam logic [3:0] B_QUEEN  = 4'd11;
  localparam logic [3:0] B_KING   = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUERY,
    ST_SELECTED,
    ST_APPLY,
    ST_OVER
  } state_t;

  typedef logic [7:0][7:0][3:0] board_t;

  function automatic logic is_white(input logic [3:0] code);
    return (code >= W_PAWN) && (code <= W_KING);
  endfunction

  function automatic logic is_black(input logic [3:0] code);
    return (code >= B_PAWN) && (code <= B_KING);
  endfunction

  function automatic logic [3:0] back_rank(input logic [2:0] col);
    logic [3:0] code;
    case (col)
      3'd0, 3'd7: code = W_ROOK;
      3'd1, 3'd6: code = W_KNIGHT;
      3'd2, 3'd5: code = W_BISHOP;
      3'd3:       code = W_QUEEN;
      default:    code = W_KING;
    endcase
    return code;
  endfunction

  // Black back rank mirrors white's, offset by six codes.
  function automatic board_t start_board();
    board_t b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[0][3'(c)] = back_rank(3'(c));
      b[1][3'(c)] = W_PAWN;
      b[6][3'(c)] = B_PAWN;
      b[7][3'(c)] = back_rank(3'(c)) + 4'd6;
    end
    return b;
  endfunction

  localparam board_t START_POS = start_board();

endpackage

// File: rtl/board_regfile.sv
// 8x8 board storage with start-position reset/reload and a two-square move write.
module board_regfile
  import chess_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_reload,
  input  logic         i_we,
  input  logic [5:0]   i_from,
  input  logic [5:0]   i_to,
  input  logic [3:0]   i_wdata,
  output board_t       o_board
);

  board_t r_board;

  // The destination write follows the source clear so it wins if both name one square.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_board <= START_POS;
    end else if (i_reload) begin
      r_board <= START_POS;
    end else if (i_we) begin
      r_board[i_from[5:3]][i_from[2:0]] <= EMPTY;
      r_board[i_to[5:3]][i_to[2:0]]     <= i_wdata;
    end
  end

  assign o_board = r_board;

endmodule

// File: rtl/move_executor.sv
// Click-driven move executor: selects pieces, queries move logic and commits legal moves.
module move_executor
  import chess_pkg::*;
#(
  parameter int MOVE_LAT     = 1,
  parameter bit AUTO_PROMOTE = 1'b1
)(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_new_game,
  input  logic                  i_click_valid,
  input  logic [5:0]            i_click_pos,
  input  logic [63:0]           i_possible_moves,
  output logic [3:0]            o_query_figure,
  output logic [5:0]            o_query_pos,
  output logic [7:0][7:0][3:0]  o_board,
  output logic                  o_turn,
  output logic                  o_sel_valid,
  output logic [5:0]            o_sel_pos,
  output logic [63:0]           o_highlight,
  output logic                  o_move_done,
  output logic                  o_move_reject,
  output logic [3:0]            o_captured,
  output logic                  o_game_over,
  output logic                  o_winner
);

  localparam logic [2:0] LAT_LAST = 3'(MOVE_LAT - 1);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic        r_turn;
  logic        r_sel_valid;
  logic [5:0]  r_sel_pos;
  logic [5:0]  r_target;
  logic [63:0] r_highlight;
  logic        r_move_done;
  logic        r_move_reject;
  logic [3:0]  r_captured;
  logic        r_game_over;
  logic        r_winner;
  logic [3:0]  r_query_figure;
  logic [5:0]  r_query_pos;

  board_t      w_board;
  logic [3:0]  w_click_fig;
  logic        w_click_own;
  logic [3:0]  w_moving;
  logic [3:0]  w_target_fig;
  logic [3:0]  w_wdata;
  logic        w_we;

  assign w_click_fig  = w_board[i_click_pos[5:3]][i_click_pos[2:0]];
  assign w_click_own  = r_turn ? is_black(w_click_fig) : is_white(w_click_fig);
  assign w_moving     = w_board[r_sel_pos[5:3]][r_sel_pos[2:0]];
  assign w_target_fig = w_board[r_target[5:3]][r_target[2:0]];
  assign w_we         = (r_state == ST_APPLY) && !i_new_game;

  always_comb begin
    w_wdata = w_moving;
    if (AUTO_PROMOTE) begin
      if (w_moving == W_PAWN && r_target[5:3] == 3'd7) begin
        w_wdata = W_QUEEN;
      end else if (w_moving == B_PAWN && r_target[5:3] == 3'd0) begin
        w_wdata = B_QUEEN;
      end
    end
  end

  board_regfile u_board (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_reload(i_new_game),
    .i_we    (w_we),
    .i_from  (r_sel_pos),
    .i_to    (r_target),
    .i_wdata (w_wdata),
    .o_board (w_board)
  );

  // new_game mirrors reset and overrides any click or state, APPLY included.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_turn         <= 1'b0;
      r_sel_valid    <= 1'b0;
      r_sel_pos      <= '0;
      r_target       <= '0;
      r_highlight    <= '0;
      r_move_done    <= 1'b0;
      r_move_reject  <= 1'b0;
      r_captured     <= EMPTY;
      r_game_over    <= 1'b0;
      r_winner       <= 1'b0;
      r_query_figure <= EMPTY;
      r_query_pos    <= '0;
    end else if (i_new_game) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_turn         <= 1'b0;
      r_sel_valid    <= 1'b0;
      r_sel_pos      <= '0;
      r_target       <= '0;
      r_highlight    <= '0;
      r_move_done    <= 1'b0;
      r_move_reject  <= 1'b0;
      r_captured     <= EMPTY;
      r_game_over    <= 1'b0;
      r_winner       <= 1'b0;
      r_query_figure <= EMPTY;
      r_query_pos    <= '0;
    end else begin
      r_move_done   <= 1'b0;
      r_move_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_click_valid && w_click_own) begin
            r_sel_pos      <= i_click_pos;
            r_query_pos    <= i_click_pos;
            r_query_figure <= w_click_fig;
            r_cnt          <= '0;
            r_state        <= ST_QUERY;
          end
        end
        ST_QUERY: begin
          if (r_cnt == LAT_LAST) begin
            r_highlight <= i_possible_moves;
            r_sel_valid <= 1'b1;
            r_state     <= ST_SELECTED;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_SELECTED: begin
          // Own-piece check precedes the mask so a marked own square never self-captures.
          if (i_click_valid) begin
            if (i_click_pos == r_sel_pos) begin
              r_sel_valid <= 1'b0;
              r_highlight <= '0;
              r_state     <= ST_IDLE;
            end else if (w_click_own) begin
              r_sel_pos      <= i_click_pos;
              r_query_pos    <= i_click_pos;
              r_query_figure <= w_click_fig;
              r_highlight    <= '0;
              r_cnt          <= '0;
              r_state        <= ST_QUERY;
            end else if (r_highlight[i_click_pos]) begin
              r_target <= i_click_pos;
              r_state  <= ST_APPLY;
            end else begin
              r_move_reject <= 1'b1;
            end
          end
        end
        ST_APPLY: begin
          r_captured  <= w_target_fig;
          r_move_done <= 1'b1;
          r_sel_valid <= 1'b0;
          r_highlight <= '0;
          if (w_target_fig == W_KING || w_target_fig == B_KING) begin
            r_game_over <= 1'b1;
            r_winner    <= r_turn;
            r_state     <= ST_OVER;
          end else begin
            r_turn  <= ~r_turn;
            r_state <= ST_IDLE;
          end
        end
        ST_OVER: begin
          r_state <= ST_OVER;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_query_figure = r_query_figure;
  assign o_query_pos    = r_query_pos;
  assign o_board        = w_board;
  assign o_turn         = r_turn;
  assign o_sel_valid    = r_sel_valid;
  assign o_sel_pos      = r_sel_pos;
  assign o_highlight    = r_highlight;
  assign o_move_done    = r_move_done;
  assign o_move_reject  = r_move_reject;
  assign o_captured     = r_captured;
  assign o_game_over    = r_game_over;
  assign o_winner       = r_winner;

endmodule

// File: tb/tb_move_executor.sv
// Scenario bench for move_executor: default, no-promotion and MOVE_LAT=3 instances.
module tb_move_executor;

  typedef logic [7:0][7:0][3:0] tbBoard_t;

  typedef struct packed {
    logic [5:0] fromPos;
    logic [5:0] toPos;
    logic [3:0] toVal;
    logic [3:0] cap;
    logic       turnAfter;
  } expMove_t;

  logic        clk;
  logic        rst_n;
  logic        newGame;
  logic        clickValid;
  logic [5:0]  clickPos;
  logic [63:0] pmask;

  logic [3:0]  qf;
  logic [5:0]  qp;
  tbBoard_t    board;
  logic        turn, selValid, done, rej, gameOver, winner;
  logic [5:0]  selPos;
  logic [63:0] hl;
  logic [3:0]  cap;

  logic [3:0]  npQf;
  logic [5:0]  npQp;
  tbBoard_t    npBoard;
  logic        npTurn, npSelValid, npDone, npRej, npGameOver, npWinner;
  logic [5:0]  npSelPos;
  logic [63:0] npHl;
  logic [3:0]  npCap;

  logic        l3ClickValid;
  logic [5:0]  l3ClickPos;
  logic [63:0] l3Mask;
  logic [3:0]  l3Qf;
  logic [5:0]  l3Qp;
  tbBoard_t    l3Board;
  logic        l3Turn, l3SelValid, l3Done, l3Rej, l3GameOver, l3Winner;
  logic [5:0]  l3SelPos;
  logic [63:0] l3Hl;
  logic [3:0]  l3Cap;

  int checks = 0;
  int errors = 0;
  expMove_t sb[$];
  tbBoard_t startRef;

  move_executor dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_new_game(newGame),
    .i_click_valid(clickValid), .i_click_pos(clickPos), .i_possible_moves(pmask),
    .o_query_figure(qf), .o_query_pos(qp), .o_board(board), .o_turn(turn),
    .o_sel_valid(selValid), .o_sel_pos(selPos), .o_highlight(hl),
    .o_move_done(done), .o_move_reject(rej), .o_captured(cap),
    .o_game_over(gameOver), .o_winner(winner)
  );

  move_executor #(.MOVE_LAT(1), .AUTO_PROMOTE(1'b0)) dut_np (
    .i_clk(clk), .i_rst_n(rst_n), .i_new_game(newGame),
    .i_click_valid(clickValid), .i_click_pos(clickPos), .i_possible_moves(pmask),
    .o_query_figure(npQf), .o_query_pos(npQp), .o_board(npBoard), .o_turn(npTurn),
    .o_sel_valid(npSelValid), .o_sel_pos(npSelPos), .o_highlight(npHl),
    .o_move_done(npDone), .o_move_reject(npRej), .o_captured(npCap),
    .o_game_over(npGameOver), .o_winner(npWinner)
  );

  move_executor #(.MOVE_LAT(3), .AUTO_PROMOTE(1'b1)) dut_l3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_new_game(newGame),
    .i_click_valid(l3ClickValid), .i_click_pos(l3ClickPos), .i_possible_moves(l3Mask),
    .o_query_figure(l3Qf), .o_query_pos(l3Qp), .o_board(l3Board), .o_turn(l3Turn),
    .o_sel_valid(l3SelValid), .o_sel_pos(l3SelPos), .o_highlight(l3Hl),
    .o_move_done(l3Done), .o_move_reject(l3Rej), .o_captured(l3Cap),
    .o_game_over(l3GameOver), .o_winner(l3Winner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic tbBoard_t refStart();
    int r0[8] = '{4, 3, 2, 5, 6, 2, 3, 4};
    int r7[8] = '{10, 9, 8, 11, 12, 8, 9, 10};
    tbBoard_t b = '0;
    for (int c = 0; c < 8; c++) begin
      b[0][c] = 4'(r0[c]);
      b[1][c] = 4'd1;
      b[6][c] = 4'd7;
      b[7][c] = 4'(r7[c]);
    end
    return b;
  endfunction

  function automatic logic [3:0] figAt(input tbBoard_t b, input logic [5:0] p);
    return b[p[5:3]][p[2:0]];
  endfunction

  // Scoreboard side: every commit pulse is matched against the oldest expected move.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_move_done got 1 expected no commit");
      end else begin
        expMove_t e;
        e = sb.pop_front();
        if (figAt(board, e.toPos) !== e.toVal || figAt(board, e.fromPos) !== 4'd0 ||
            cap !== e.cap || turn !== e.turnAfter) begin
          errors++;
          $display("[TB] FAIL commit_%0d_to_%0d got to=%0d from=%0d cap=%0d turn=%0d expected to=%0d from=0 cap=%0d turn=%0d",
                   e.fromPos, e.toPos, figAt(board, e.toPos), figAt(board, e.fromPos), cap, turn,
                   e.toVal, e.cap, e.turnAfter);
        end
      end
    end
  end

  task automatic applyClick(input logic [5:0] pos);
    @(negedge clk);
    clickValid = 1'b1;
    clickPos   = pos;
    @(negedge clk);
    clickValid = 1'b0;
  endtask

  task automatic applyL3Click(input logic [5:0] pos);
    @(negedge clk);
    l3ClickValid = 1'b1;
    l3ClickPos   = pos;
    @(negedge clk);
    l3ClickValid = 1'b0;
  endtask

  task automatic applyNewGame();
    @(negedge clk);
    newGame = 1'b1;
    @(negedge clk);
    newGame = 1'b0;
  endtask

  task automatic doSelect(input logic [5:0] pos, input logic [63:0] mask);
    pmask = mask;
    applyClick(pos);
    @(negedge clk);
    checks++;
    if (selValid !== 1'b1 || hl !== mask || selPos !== pos) begin
      errors++;
      $display("[TB] FAIL select_%0d got sel=%0b hl=%h pos=%0d expected sel=1 hl=%h pos=%0d",
               pos, selValid, hl, selPos, mask, pos);
    end
  endtask

  task automatic doMove(input logic [5:0] fromPos, input logic [5:0] toPos,
                        input logic [3:0] toVal, input logic [3:0] expCap, input logic turnAfter);
    expMove_t e;
    doSelect(fromPos, 64'd1 << toPos);
    e.fromPos = fromPos; e.toPos = toPos; e.toVal = toVal; e.cap = expCap; e.turnAfter = turnAfter;
    sb.push_back(e);
    applyClick(toPos);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_early got %0b expected 0", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_pulse got %0b expected 1", done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || selValid !== 1'b0 || hl !== 64'd0) begin
      errors++;
      $display("[TB] FAIL after_commit got done=%0b sel=%0b hl=%h expected 0 0 0", done, selValid, hl);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL commit_timeout got pending=%0d expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (board !== startRef || l3Board !== startRef || turn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_board got turn=%0b board_ok=%0b expected start position turn=0",
               turn, board === startRef);
    end
    checks++;
    if (selValid !== 0 || selPos !== 0 || hl !== 0 || done !== 0 || rej !== 0 ||
        cap !== 0 || gameOver !== 0 || winner !== 0 || qf !== 0 || qp !== 0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got sel=%0b pos=%0d hl=%h done=%0b rej=%0b cap=%0d go=%0b win=%0b qf=%0d qp=%0d expected all 0",
               selValid, selPos, hl, done, rej, cap, gameOver, winner, qf, qp);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_move();
    doSelect(6'h0C, (64'd1 << 20) | (64'd1 << 28));
    checks++;
    if (hl !== 64'h0000_0000_1010_0000 || qp !== 6'h0C || qf !== 4'd1) begin
      errors++;
      $display("[TB] FAIL basic_query got hl=%h qp=%0d qf=%0d expected hl=0000000010100000 qp=12 qf=1", hl, qp, qf);
    end
    doMove_tail(6'h0C, 6'd28);
  endtask

  // Finishes a move whose piece is already selected.
  task automatic doMove_tail(input logic [5:0] fromPos, input logic [5:0] toPos);
    expMove_t e;
    e.fromPos = fromPos; e.toPos = toPos; e.toVal = 4'd1; e.cap = 4'd0; e.turnAfter = 1'b1;
    sb.push_back(e);
    applyClick(toPos);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (board[3][4] !== 4'd1 || board[1][4] !== 4'd0 || turn !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL basic_commit got b34=%0d b14=%0d turn=%0b pending=%0d expected 1 0 1 0",
               board[3][4], board[1][4], turn, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_ignore_enemy();
    logic sawPulse;
    applyNewGame();
    sawPulse = 1'b0;
    applyClick(6'h34);
    applyClick(6'h20);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rej || done) sawPulse = 1'b1;
    end
    checks++;
    if (selValid !== 1'b0 || qp !== 6'd0 || sawPulse !== 1'b0 || turn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_enemy got sel=%0b qp=%0d pulse=%0b turn=%0b expected 0 0 0 0",
               selValid, qp, sawPulse, turn);
    end
  endtask

  task automatic test_reject_deselect();
    logic [63:0] m;
    m = (64'd1 << 20) | (64'd1 << 11);
    doSelect(6'd12, m);
    applyClick(6'd36);
    checks++;
    if (rej !== 1'b1 || selValid !== 1'b1 || hl !== m) begin
      errors++;
      $display("[TB] FAIL reject_pulse got rej=%0b sel=%0b hl=%h expected 1 1 %h", rej, selValid, hl, m);
    end
    @(negedge clk);
    checks++;
    if (rej !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reject_width got %0b expected 0", rej);
    end
    pmask = 64'd1 << 19;
    applyClick(6'd11);
    checks++;
    if (hl !== 64'd0 || qp !== 6'd11 || qf !== 4'd1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reselect got hl=%h qp=%0d qf=%0d done=%0b expected 0 11 1 0", hl, qp, qf, done);
    end
    @(negedge clk);
    checks++;
    if (hl !== (64'd1 << 19) || selPos !== 6'd11 || board[1][3] !== 4'd1) begin
      errors++;
      $display("[TB] FAIL reselect_mask got hl=%h pos=%0d b13=%0d expected %h 11 1",
               hl, selPos, board[1][3], 64'd1 << 19);
    end
    applyClick(6'd11);
    checks++;
    if (selValid !== 1'b0 || hl !== 64'd0) begin
      errors++;
      $display("[TB] FAIL deselect got sel=%0b hl=%h expected 0 0", selValid, hl);
    end
  endtask

  task automatic test_king_capture();
    doMove(6'd3, 6'd60, 4'd5, 4'd12, 1'b0);
    checks++;
    if (gameOver !== 1'b1 || winner !== 1'b0 || turn !== 1'b0 || cap !== 4'd12) begin
      errors++;
      $display("[TB] FAIL white_wins got go=%0b win=%0b turn=%0b cap=%0d expected 1 0 0 12",
               gameOver, winner, turn, cap);
    end
    pmask = 64'd1 << 20;
    applyClick(6'd12);
    repeat (3) @(negedge clk);
    checks++;
    if (selValid !== 1'b0 || qp !== 6'd3 || board[1][4] !== 4'd1 || gameOver !== 1'b1) begin
      errors++;
      $display("[TB] FAIL over_ignores got sel=%0b qp=%0d b14=%0d go=%0b expected 0 3 1 1",
               selValid, qp, board[1][4], gameOver);
    end
    @(negedge clk);
    newGame = 1'b1; clickValid = 1'b1; clickPos = 6'd12;
    @(negedge clk);
    newGame = 1'b0; clickValid = 1'b0;
    @(negedge clk);
    checks++;
    if (board !== startRef || gameOver !== 1'b0 || cap !== 4'd0 || qp !== 6'd0 || selValid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL new_game got board_ok=%0b go=%0b cap=%0d qp=%0d sel=%0b expected 1 0 0 0 0",
               board === startRef, gameOver, cap, qp, selValid);
    end
  endtask

  task automatic test_black_win();
    applyNewGame();
    doMove(6'd12, 6'd28, 4'd1, 4'd0, 1'b1);
    doMove(6'd59, 6'd4, 4'd11, 4'd6, 1'b1);
    checks++;
    if (gameOver !== 1'b1 || winner !== 1'b1 || turn !== 1'b1) begin
      errors++;
      $display("[TB] FAIL black_wins got go=%0b win=%0b turn=%0b expected 1 1 1", gameOver, winner, turn);
    end
  endtask

  task automatic test_promotion();
    applyNewGame();
    doMove(6'd8, 6'd48, 4'd1, 4'd7, 1'b1);
    doMove(6'd49, 6'd41, 4'd7, 4'd0, 1'b0);
    doMove(6'd48, 6'd56, 4'd5, 4'd10, 1'b1);
    checks++;
    if (board[7][0] !== 4'd5 || npBoard[7][0] !== 4'd1 || npCap !== 4'd10 || npBoard[6][0] !== 4'd0) begin
      errors++;
      $display("[TB] FAIL promotion got promo=%0d nopromo=%0d npcap=%0d np60=%0d expected 5 1 10 0",
               board[7][0], npBoard[7][0], npCap, npBoard[6][0]);
    end
  endtask

  task automatic test_latency3();
    logic [63:0] maskA, maskB;
    maskA = 64'd1 << 20;
    maskB = 64'd1 << 28;
    l3Mask = maskA;
    applyL3Click(6'd12);
    @(negedge clk);
    checks++;
    if (l3SelValid !== 1'b0 || l3Qp !== 6'd12) begin
      errors++;
      $display("[TB] FAIL lat3_edge1 got sel=%0b qp=%0d expected 0 12", l3SelValid, l3Qp);
    end
    @(negedge clk);
    checks++;
    if (l3SelValid !== 1'b0 || l3Hl !== 64'd0) begin
      errors++;
      $display("[TB] FAIL lat3_edge2 got sel=%0b hl=%h expected 0 0", l3SelValid, l3Hl);
    end
    l3Mask = maskB;
    @(negedge clk);
    checks++;
    if (l3SelValid !== 1'b1 || l3Hl !== maskB) begin
      errors++;
      $display("[TB] FAIL lat3_sample got sel=%0b hl=%h expected 1 %h", l3SelValid, l3Hl, maskB);
    end
    applyL3Click(6'd12);
    applyL3Click(6'd12);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (l3Qp !== 6'd0 || l3Qf !== 4'd0 || l3SelPos !== 6'd0 || l3SelValid !== 1'b0 ||
        l3Hl !== 64'd0 || l3Board !== startRef || l3Turn !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset got qp=%0d qf=%0d pos=%0d sel=%0b hl=%h board_ok=%0b turn=%0b expected all 0 and start",
               l3Qp, l3Qf, l3SelPos, l3SelValid, l3Hl, l3Board === startRef, l3Turn);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (l3SelValid !== 1'b0 || l3Hl !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_idle got sel=%0b hl=%h expected 0 0", l3SelValid, l3Hl);
    end
  endtask

  initial begin
    startRef     = refStart();
    rst_n        = 1'b1;
    newGame      = 1'b0;
    clickValid   = 1'b0;
    clickPos     = '0;
    pmask        = '0;
    l3ClickValid = 1'b0;
    l3ClickPos   = '0;
    l3Mask       = '0;
    #1;
    test_reset();
    test_basic_move();
    test_ignore_enemy();
    test_reject_deselect();
    test_king_capture();
    test_black_win();
    test_promotion();
    test_latency3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
